// File: rtl/chart_sequencer.sv
// chart_sequencer: walks a {cmd, delay} chart ROM and issues frame-timed note
// commands to the pattern block over a valid/ready handshake.
module chart_sequencer #(
  parameter int ADDR_W    = 8,
  parameter int CHART_LEN = 256,
  parameter int DELAY_W   = 12
) (
  input  logic              CLOCK_25,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic [9:0]        next_x,
  input  logic [9:0]        next_y,
  input  logic [15:0]       rom_data,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [3:0]        command_out,
  output logic              cmd_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] entry_idx
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CHART_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_WAIT, S_ISSUE, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [DELAY_W-1:0] cnt;
  logic               scan_zero, scan_zero_q, frame_tick, tick_en;
  logic [3:0]         rom_cmd;
  logic [DELAY_W-1:0] rom_dly;

  assign rom_cmd    = rom_data[15:12];
  assign rom_dly    = rom_data[DELAY_W-1:0];
  // Frame starts when the scan position lands on (0,0); a held (0,0) is one tick.
  assign scan_zero  = (next_x == 10'd0) && (next_y == 10'd0);
  assign frame_tick = scan_zero && !scan_zero_q;
  assign tick_en    = frame_tick && !pause;

  assign cmd_valid  = (state == S_ISSUE);
  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign done       = (state == S_DONE);

  // State register.
  always_ff @(posedge CLOCK_25) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; start is only honoured from IDLE or DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_LOAD;
      S_LOAD: begin
        if (rom_cmd == 4'd0)                 state_nxt = S_DONE;
        else if (rom_dly == '0)              state_nxt = S_ISSUE;
        else                                 state_nxt = S_WAIT;
      end
      S_WAIT:  if (tick_en && cnt == DELAY_W'(1)) state_nxt = S_ISSUE;
      S_ISSUE: if (cmd_ready) state_nxt = (rom_addr == LAST_ADDR) ? S_DONE : S_FETCH;
      S_DONE:  if (start) state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: ROM address, latched entry, frame countdown and tick edge register.
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      rom_addr    <= '0;
      command_out <= 4'd0;
      entry_idx   <= '0;
      cnt         <= '0;
      scan_zero_q <= 1'b0;
    end else begin
      scan_zero_q <= scan_zero;
      case (state)
        S_IDLE, S_DONE: if (start) rom_addr <= '0;
        S_LOAD: begin
          command_out <= rom_cmd;
          cnt         <= rom_dly;
          entry_idx   <= rom_addr;
        end
        S_WAIT:  if (tick_en) cnt <= cnt - DELAY_W'(1);
        S_ISSUE: if (cmd_ready && rom_addr != LAST_ADDR) rom_addr <= rom_addr + ADDR_W'(1);
        default: ;
      endcase
    end
  end

endmodule
